// File: rtl/fmcw_chirp_sequencer_if.sv
// Control/status bundle between the host registers and the chirp sequencer.
interface fmcw_chirp_sequencer_if #(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned SAMP_W  = 12,
  parameter int unsigned CHIRP_W = 8
);
  logic               start;
  logic               abort;
  logic [DIV_W-1:0]   div_cfg;
  logic [SAMP_W-1:0]  samples_per_chirp;
  logic [SAMP_W-1:0]  gap_samples;
  logic [CHIRP_W-1:0] chirps_per_frame;
  logic               busy;
  logic               ramp_active;
  logic               chirp_start;
  logic               sample_stb;
  logic [SAMP_W-1:0]  sample_idx;
  logic [CHIRP_W-1:0] chirp_idx;
  logic               frame_done;

  // Host / control side
  modport master (
    output start, abort, div_cfg, samples_per_chirp, gap_samples, chirps_per_frame,
    input  busy, ramp_active, chirp_start, sample_stb, sample_idx, chirp_idx, frame_done
  );

  // Sequencer side
  modport slave (
    input  start, abort, div_cfg, samples_per_chirp, gap_samples, chirps_per_frame,
    output busy, ramp_active, chirp_start, sample_stb, sample_idx, chirp_idx, frame_done
  );
endinterface

// File: rtl/fmcw_chirp_sequencer.sv
// FMCW frame sequencer: sample-rate enable, ramp trigger, ADC strobes, gaps, frame end.
// Internal counters describe the current cycle; outputs are registered copies of
// the values the next cycle will have, so every output is a flop.
module fmcw_chirp_sequencer #(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned SAMP_W  = 12,
  parameter int unsigned CHIRP_W = 8
) (
  input  logic clk,
  input  logic rst,
  fmcw_chirp_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, GAP = 2'd2} state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   tick, tick_n, p_q, p_n;
  logic [SAMP_W-1:0]  samp, samp_n, grp, grp_n, n_q, n_n, g_q, g_n;
  logic [CHIRP_W-1:0] chirp, chirp_n, c_q, c_n;
  logic               tick_last;
  logic               done_n, busy_n, ramp_n, cs_n, stb_n;
  logic [SAMP_W-1:0]  idx_n;
  logic [CHIRP_W-1:0] cidx_n;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state, counter and next-output logic
  always_comb begin
    state_n   = state;
    tick_n    = tick;
    samp_n    = samp;
    grp_n     = grp;
    chirp_n   = chirp;
    p_n       = p_q;
    n_n       = n_q;
    g_n       = g_q;
    c_n       = c_q;
    done_n    = 1'b0;
    tick_last = (tick == p_q - DIV_W'(1));
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort && (bus.samples_per_chirp != '0) &&
            (bus.chirps_per_frame != '0)) begin
          state_n = RAMP;
          tick_n  = '0;
          samp_n  = '0;
          grp_n   = '0;
          chirp_n = '0;
          p_n     = (bus.div_cfg == '0) ? DIV_W'(1) : bus.div_cfg;
          n_n     = bus.samples_per_chirp;
          g_n     = bus.gap_samples;
          c_n     = bus.chirps_per_frame;
        end
      end
      RAMP: begin
        if (bus.abort) begin
          state_n = IDLE;
          tick_n  = '0;
          samp_n  = '0;
          grp_n   = '0;
          chirp_n = '0;
        end else if (tick_last) begin
          tick_n = '0;
          if (samp == n_q - SAMP_W'(1)) begin
            state_n = GAP;
            grp_n   = '0;
          end else begin
            samp_n = samp + SAMP_W'(1);
          end
        end else begin
          tick_n = tick + DIV_W'(1);
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_n = IDLE;
          tick_n  = '0;
          samp_n  = '0;
          grp_n   = '0;
          chirp_n = '0;
        end else if ((g_q == '0) || (tick_last && (grp == g_q - SAMP_W'(1)))) begin
          tick_n = '0;
          samp_n = '0;
          grp_n  = '0;
          if (chirp == c_q - CHIRP_W'(1)) begin
            state_n = IDLE;
            chirp_n = '0;
            done_n  = 1'b1;
          end else begin
            state_n = RAMP;
            chirp_n = chirp + CHIRP_W'(1);
          end
        end else if (tick_last) begin
          tick_n = '0;
          grp_n  = grp + SAMP_W'(1);
        end else begin
          tick_n = tick + DIV_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
    ramp_n = (state_n == RAMP);
    cs_n   = (state_n == RAMP) && (state != RAMP);
    stb_n  = (state_n == RAMP) && (tick_n == p_n - DIV_W'(1));
    idx_n  = ramp_n ? samp_n : '0;
    cidx_n = busy_n ? chirp_n : '0;
  end

  // Counters, latched configuration and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick             <= '0;
      samp             <= '0;
      grp              <= '0;
      chirp            <= '0;
      p_q              <= '0;
      n_q              <= '0;
      g_q              <= '0;
      c_q              <= '0;
      bus.busy         <= 1'b0;
      bus.ramp_active  <= 1'b0;
      bus.chirp_start  <= 1'b0;
      bus.sample_stb   <= 1'b0;
      bus.sample_idx   <= '0;
      bus.chirp_idx    <= '0;
      bus.frame_done   <= 1'b0;
    end else begin
      tick             <= tick_n;
      samp             <= samp_n;
      grp              <= grp_n;
      chirp            <= chirp_n;
      p_q              <= p_n;
      n_q              <= n_n;
      g_q              <= g_n;
      c_q              <= c_n;
      bus.busy         <= busy_n;
      bus.ramp_active  <= ramp_n;
      bus.chirp_start  <= cs_n;
      bus.sample_stb   <= stb_n;
      bus.sample_idx   <= idx_n;
      bus.chirp_idx    <= cidx_n;
      bus.frame_done   <= done_n;
    end
  end

endmodule

// File: tb/tb_fmcw_chirp_sequencer.sv
// Directed bench for fmcw_chirp_sequencer: frame vectors plus abort/reset/ignore sequences.
module tb_fmcw_chirp_sequencer;
  localparam int unsigned DIV_W   = 8;
  localparam int unsigned SAMP_W  = 12;
  localparam int unsigned CHIRP_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fmcw_chirp_sequencer_if #(.DIV_W(DIV_W), .SAMP_W(SAMP_W), .CHIRP_W(CHIRP_W)) bus ();

  fmcw_chirp_sequencer #(.DIV_W(DIV_W), .SAMP_W(SAMP_W), .CHIRP_W(CHIRP_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int p, n, g, c;
    int stb, first, last, cs, ramp, busyc, done;
  } vec_t;

  vec_t vecs [5];
  int total = 0;
  int bad   = 0;
  int s_stb, s_first, s_last, s_cs, s_ramp, s_busy, s_done, s_idx_bad, s_extra;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({bus.busy, bus.ramp_active, bus.chirp_start, bus.sample_stb,
                 bus.frame_done, bus.sample_idx, bus.chirp_idx});
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Start a frame and observe until frame_done (bounded); optionally disturb at cycle 5
  task automatic run_frame(input int p, input int n, input int g, input int c,
                           input bit disturb);
    bus.div_cfg           = DIV_W'(p);
    bus.samples_per_chirp = SAMP_W'(n);
    bus.gap_samples       = SAMP_W'(g);
    bus.chirps_per_frame  = CHIRP_W'(c);
    bus.start             = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    s_stb = 0; s_first = 0; s_last = 0; s_cs = 0; s_ramp = 0;
    s_busy = 0; s_done = 0; s_idx_bad = 0;
    for (int cyc = 1; cyc <= 3000 && s_done == 0; cyc++) begin
      if (bus.sample_stb) begin
        if (s_stb == 0) s_first = cyc;
        s_last = cyc;
        if (int'(bus.sample_idx) != s_stb % n || int'(bus.chirp_idx) != s_stb / n)
          s_idx_bad++;
        s_stb++;
      end
      if (bus.chirp_start) s_cs++;
      if (bus.ramp_active) s_ramp++;
      if (bus.busy) s_busy++;
      if (bus.frame_done) s_done = cyc;
      if (disturb && cyc == 5) begin
        bus.start             = 1'b1;
        bus.div_cfg           = DIV_W'(1);
        bus.samples_per_chirp = SAMP_W'(1);
      end
      if (disturb && cyc == 6) bus.start = 1'b0;
      if (s_done == 0) next_cycle();
    end
  endtask

  initial begin
    //            p   n  g  c  stb first last cs ramp busy done
    vecs[0] = '{16,  4, 2, 2,  8,  16, 160, 2, 128, 192, 193};
    vecs[1] = '{ 0,  3, 0, 1,  3,   1,   3, 1,   3,   4,   5};
    vecs[2] = '{ 1,  1, 0, 3,  3,   1,   5, 3,   3,   6,   7};
    vecs[3] = '{ 3,  2, 1, 2,  4,   3,  15, 2,  12,  18,  19};
    vecs[4] = '{ 2,  5, 3, 1,  5,   2,  10, 1,  10,  16,  17};

    bus.start = 1'b0; bus.abort = 1'b0; bus.div_cfg = '0;
    bus.samples_per_chirp = '0; bus.gap_samples = '0; bus.chirps_per_frame = '0;
    rst = 1'b1;
    #1;
    check("reset_outputs", outs(), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    next_cycle();
    check("idle_after_reset", outs(), 0);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].p, vecs[i].n, vecs[i].g, vecs[i].c, 1'b0);
      check($sformatf("v%0d_stb_count", i), s_stb, vecs[i].stb);
      check($sformatf("v%0d_first_stb", i), s_first, vecs[i].first);
      check($sformatf("v%0d_last_stb", i), s_last, vecs[i].last);
      check($sformatf("v%0d_chirp_starts", i), s_cs, vecs[i].cs);
      check($sformatf("v%0d_ramp_cycles", i), s_ramp, vecs[i].ramp);
      check($sformatf("v%0d_busy_cycles", i), s_busy, vecs[i].busyc);
      check($sformatf("v%0d_done_cycle", i), s_done, vecs[i].done);
      check($sformatf("v%0d_idx_errors", i), s_idx_bad, 0);
      check($sformatf("v%0d_busy_at_done", i), int'(bus.busy), 0);
      next_cycle();
    end

    // Abort in RAMP at the edge ending cycle 10
    bus.div_cfg = DIV_W'(4); bus.samples_per_chirp = SAMP_W'(8);
    bus.gap_samples = '0; bus.chirps_per_frame = CHIRP_W'(1);
    bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    s_stb = 0; s_first = 0; s_last = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (bus.sample_stb) begin
        if (s_stb == 0) s_first = cyc;
        s_last = cyc;
        s_stb++;
      end
      if (cyc < 10) next_cycle();
    end
    bus.abort = 1'b1;
    next_cycle();
    bus.abort = 1'b0;
    check("abort_outputs_zero", outs(), 0);
    check("abort_stb_count", s_stb, 2);
    check("abort_first_stb", s_first, 4);
    check("abort_last_stb", s_last, 8);
    s_extra = 0;
    for (int k = 0; k < 60; k++) begin
      if (bus.frame_done || bus.busy || bus.sample_stb) s_extra++;
      next_cycle();
    end
    check("abort_no_done_or_activity", s_extra, 0);

    // Start with N=0 or C=0 is ignored
    bus.div_cfg = DIV_W'(1); bus.gap_samples = '0;
    bus.samples_per_chirp = '0; bus.chirps_per_frame = CHIRP_W'(2);
    bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    s_extra = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.busy) s_extra++;
      next_cycle();
    end
    check("ignore_n_zero", s_extra, 0);
    bus.samples_per_chirp = SAMP_W'(2); bus.chirps_per_frame = '0;
    bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    s_extra = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.busy) s_extra++;
      next_cycle();
    end
    check("ignore_c_zero", s_extra, 0);

    // Mid-frame start pulse and config change: latched timing holds
    run_frame(3, 2, 1, 2, 1'b1);
    check("mid_done_cycle", s_done, 19);
    check("mid_stb_count", s_stb, 4);
    check("mid_idx_errors", s_idx_bad, 0);
    next_cycle();
    check("mid_no_queued_frame", int'(bus.busy), 0);
    // Next frame picks up P=1, N=1 (G=1, C=2 still on the inputs): T=2
    run_frame(1, 1, 1, 2, 1'b0);
    check("new_cfg_done_cycle", s_done, 5);
    check("new_cfg_stb_count", s_stb, 2);
    next_cycle();

    // Async reset in GAP of chirp 0 with C=3 (P=2, N=2, G=2: GAP in cycles 5..8)
    bus.div_cfg = DIV_W'(2); bus.samples_per_chirp = SAMP_W'(2);
    bus.gap_samples = SAMP_W'(2); bus.chirps_per_frame = CHIRP_W'(3);
    bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    repeat (5) next_cycle();
    check("in_gap_busy_noramp", int'({bus.busy, bus.ramp_active}), 2);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    s_extra = 0;
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      if (outs() != 0) s_extra++;
    end
    check("post_reset_stays_idle", s_extra, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
